// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU in EX.
// Requests a pipeline freeze while computing and holds its result until the
// stall controller lets EX hand off to EX/MEM.
//
// state | meaning
// IDLE  | waiting for a divide in EX; fast paths resolve here
// CALC  | one quotient bit per cycle, MSB first
// DONE  | result final and held until EX advances
module div_unit #(
  parameter int WIDTH   = 32,
  parameter int STALL_W = 6,
  parameter int EX_BIT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  output logic               stallreq_ex,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             sel_rem_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;

  logic             is_signed;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   rem_sh;
  logic             trial_ge;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             ex_hold;
  logic             unused_stall;

  // Only the EX/MEM hold bit matters here; other stages' bits are ignored.
  assign ex_hold      = stall[EX_BIT];
  assign unused_stall = ^stall;

  // Operand decode in IDLE and one restoring step in CALC.
  always_comb begin
    is_signed = ~op[0];
    div_zero  = (src2 == '0);
    overflow  = is_signed && (src1 == MIN_NEG) && (&src2);
    abs1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
    abs2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
    rem_sh    = {rem_q, dvd_q[WIDTH-1]};
    trial_ge  = (rem_sh >= {1'b0, dvs_q});
    quo_d     = {dvd_q[WIDTH-2:0], trial_ge};
    // when the trial succeeds the difference is below the divisor, so it fits WIDTH bits
    rem_d     = trial_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    quo_fix   = neg_quo_q ? -quo_d : quo_d;
    rem_fix   = neg_rem_q ? -rem_d : rem_d;
  end

  // Freeze request: the IDLE cycle that accepts the op plus every CALC cycle.
  assign stallreq_ex = !flush && ((state_q == IDLE && start) || state_q == CALC);

  // Divider FSM with registered result and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              result_q <= op[1] ? src1 : '1;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else if (overflow) begin
              result_q <= op[1] ? '0 : MIN_NEG;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              dvd_q     <= abs1;
              dvs_q     <= abs2;
              rem_q     <= '0;
              count_q   <= '0;
              neg_quo_q <= is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
              neg_rem_q <= is_signed && src1[WIDTH-1];
              sel_rem_q <= op[1];
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          dvd_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            result_q <= sel_rem_q ? rem_fix : quo_fix;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // stay put while EX/MEM is held, even though start is still high
          if (!ex_hold) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an
// arithmetic reference model, with a simple stall-controller model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic [5:0]  stall;
  logic        stallreq_ex;
  logic [31:0] result;
  logic        result_valid;
  logic        hold_ex;

  int n_checks;
  int n_fail;

  div_unit #(.WIDTH(32), .STALL_W(6), .EX_BIT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .src1         (src1),
    .src2         (src2),
    .flush        (flush),
    .stall        (stall),
    .stallreq_ex  (stallreq_ex),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall controller: an EX request freezes IF..EX; hold_ex models a downstream hold.
  always_comb begin
    stall = 6'b000000;
    if (stallreq_ex) stall = 6'b001111;
    if (hold_ex)     stall = stall | 6'b001000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V division semantics computed with plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold_n);
    int cnt;
    int budget;
    logic [31:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    flush = 1'b0;
    #1;
    check("idle_valid", {31'd0, result_valid}, 32'd0);
    cnt = 0;
    budget = 0;
    while (!result_valid && budget < 100) begin
      if (stallreq_ex) cnt++;
      budget++;
      @(negedge clk);
      #1;
    end
    check("done_valid", {31'd0, result_valid}, 32'd1);
    check("stall_cycles", 32'(cnt), is_fast(o, a, b) ? 32'd1 : 32'd33);
    check("result", result, exp);
    check("done_req", {31'd0, stallreq_ex}, 32'd0);
    if (hold_n > 0) begin
      hold_ex = 1'b1;
      for (int k = 0; k < hold_n; k++) begin
        @(negedge clk);
        #1;
        check("hold_valid", {31'd0, result_valid}, 32'd1);
        check("hold_result", result, exp);
        check("hold_req", {31'd0, stallreq_ex}, 32'd0);
      end
      hold_ex = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int sel;
    n_checks = 0;
    n_fail   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    src1    = '0;
    src2    = '0;
    flush   = 1'b0;
    hold_ex = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_req", {31'd0, stallreq_ex}, 32'd0);
    rst_n = 1'b1;

    // directed cases
    do_op(2'b01, 32'd100, 32'd7, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b00, 32'd5, 32'd0, 0);
    do_op(2'b10, 32'd5, 32'd0, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 4);
    do_op(2'b01, 32'd9, 32'd3, 0);

    // flush at CALC count 10
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    src1  = 32'd1000;
    src2  = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_req", {31'd0, stallreq_ex}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush_idle_req", {31'd0, stallreq_ex}, 32'd0);
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    do_op(2'b11, 32'd1000, 32'd7, 0);

    // reset mid-CALC
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    src1  = 32'd12345;
    src2  = 32'd11;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_valid", {31'd0, result_valid}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_req", {31'd0, stallreq_ex}, 32'd0);
    rst_n = 1'b1;

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -(32'($urandom_range(1, 15)));
        4: rb = ra;
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, (i % 7 == 3) ? 2 : 0);
    end

    @(negedge clk);
    start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
